ifft_8p_seq: RTL and testbench

Sequential 8-point radix-2 inverse FFT. It is the inverse-direction companion to the team's 8-point forward FFT and maps its spectrum output back to the time domain.
Accepts one complex sample per handshake, in natural order k=0..7, then computes in place with one shared butterfly over 12 cycles. Streams 8 time-domain samples out in natural order with a last flag.
Output is normalised by 1/N, so a forward-FFT/IFFT round trip returns the input within quantisation error.

---
 rtl/ifft_8p_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_ifft_8p_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_8p_seq.sv
`default_nettype none
// ============================================================================
// ifft_8p_seq : sequential 8-point radix-2 inverse FFT, one shared butterfly,
//               1/8 output scaling, ready/valid streaming in and out.
// Revision    : 1.0
// ============================================================================
module ifft_8p_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int N          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] in_real_i,
    input  logic signed [DATA_WIDTH-1:0] in_imag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH-1:0] out_real_o,
    output logic signed [DATA_WIDTH-1:0] out_imag_o,
    output logic                         out_last_o
);
    localparam int c_mw     = 2 * DATA_WIDTH;
    localparam int c_tw_one = 1 << FRAC_BITS;
    localparam int c_tw_r2  = (46341 * c_tw_one + 32768) >> 16;

    generate
        if (N != 8) begin : g_bad_n
            $error("ifft_8p_seq supports N = 8 only");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              k_q;
    logic [2:0]              n_q;
    logic [1:0]              s_q;
    logic [1:0]              b_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic signed [DATA_WIDTH-1:0] out_re_q;
    logic signed [DATA_WIDTH-1:0] out_im_q;
    logic signed [DATA_WIDTH-1:0] mem_re_q [8];
    logic signed [DATA_WIDTH-1:0] mem_im_q [8];

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [2:0]              w_load_addr;
    logic [2:0]              w_n_next;
    logic [2:0]              w_top;
    logic [2:0]              w_bot;
    logic [1:0]              w_tw_idx;
    logic signed [DATA_WIDTH-1:0] w_tw_re;
    logic signed [DATA_WIDTH-1:0] w_tw_im;

    assign w_in_fire   = in_valid_i & in_ready_q;
    assign w_out_fire  = out_valid_q & out_ready_i;
    assign w_load_addr = {k_q[0], k_q[1], k_q[2]};
    assign w_n_next    = n_q + 3'd1;

    // Butterfly addressing: span 1, 2, 4 for stages 0, 1, 2.
    always_comb begin
        w_top    = 3'd0;
        w_bot    = 3'd0;
        w_tw_idx = 2'd0;
        case (s_q)
            2'd0: begin
                w_top    = {b_q, 1'b0};
                w_bot    = {b_q, 1'b1};
                w_tw_idx = 2'd0;
            end
            2'd1: begin
                w_top    = {b_q[1], 1'b0, b_q[0]};
                w_bot    = {b_q[1], 1'b1, b_q[0]};
                w_tw_idx = {b_q[0], 1'b0};
            end
            default: begin
                w_top    = {1'b0, b_q};
                w_bot    = {1'b1, b_q};
                w_tw_idx = b_q;
            end
        endcase
    end

    always_comb begin
        w_tw_re = '0;
        w_tw_im = '0;
        case (w_tw_idx)
            2'd0: begin
                w_tw_re = DATA_WIDTH'(c_tw_one);
                w_tw_im = '0;
            end
            2'd1: begin
                w_tw_re = DATA_WIDTH'(c_tw_r2);
                w_tw_im = DATA_WIDTH'(c_tw_r2);
            end
            2'd2: begin
                w_tw_re = '0;
                w_tw_im = DATA_WIDTH'(c_tw_one);
            end
            default: begin
                w_tw_re = DATA_WIDTH'(-c_tw_r2);
                w_tw_im = DATA_WIDTH'(c_tw_r2);
            end
        endcase
    end

    logic signed [DATA_WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [c_mw-1:0]       w_m_rr, w_m_ii, w_m_ri, w_m_ir;
    logic signed [c_mw:0]         w_p_re_full, w_p_im_full;
    logic signed [DATA_WIDTH:0]   w_p_re, w_p_im;
    logic signed [DATA_WIDTH:0]   w_s0_re, w_s0_im, w_s1_re, w_s1_im;
    logic signed [DATA_WIDTH-1:0] w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic                         w_unused;

    assign w_a_re = mem_re_q[w_top];
    assign w_a_im = mem_im_q[w_top];
    assign w_b_re = mem_re_q[w_bot];
    assign w_b_im = mem_im_q[w_bot];

    assign w_m_rr = c_mw'(w_b_re) * c_mw'(w_tw_re);
    assign w_m_ii = c_mw'(w_b_im) * c_mw'(w_tw_im);
    assign w_m_ri = c_mw'(w_b_re) * c_mw'(w_tw_im);
    assign w_m_ir = c_mw'(w_b_im) * c_mw'(w_tw_re);

    assign w_p_re_full = (c_mw+1)'(w_m_rr) - (c_mw+1)'(w_m_ii);
    assign w_p_im_full = (c_mw+1)'(w_m_ri) + (c_mw+1)'(w_m_ir);

    // Dropping the low FRAC_BITS is the floor of the arithmetic shift.
    assign w_p_re = w_p_re_full[DATA_WIDTH+FRAC_BITS:FRAC_BITS];
    assign w_p_im = w_p_im_full[DATA_WIDTH+FRAC_BITS:FRAC_BITS];

    assign w_s0_re = (DATA_WIDTH+1)'(w_a_re) + w_p_re;
    assign w_s0_im = (DATA_WIDTH+1)'(w_a_im) + w_p_im;
    assign w_s1_re = (DATA_WIDTH+1)'(w_a_re) - w_p_re;
    assign w_s1_im = (DATA_WIDTH+1)'(w_a_im) - w_p_im;

    assign w_y0_re = w_s0_re[DATA_WIDTH:1];
    assign w_y0_im = w_s0_im[DATA_WIDTH:1];
    assign w_y1_re = w_s1_re[DATA_WIDTH:1];
    assign w_y1_im = w_s1_im[DATA_WIDTH:1];

    assign w_unused = ^{w_p_re_full, w_p_im_full, w_s0_re, w_s0_im, w_s1_re, w_s1_im};

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && w_in_fire) begin
            mem_re_q[w_load_addr] <= in_real_i;
            mem_im_q[w_load_addr] <= in_imag_i;
        end else if (state_q == S_COMPUTE) begin
            mem_re_q[w_top] <= w_y0_re;
            mem_im_q[w_top] <= w_y0_im;
            mem_re_q[w_bot] <= w_y1_re;
            mem_im_q[w_bot] <= w_y1_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            k_q         <= 3'd0;
            n_q         <= 3'd0;
            s_q         <= 2'd0;
            b_q         <= 2'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (w_in_fire) begin
                        k_q <= k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            state_q    <= S_COMPUTE;
                            in_ready_q <= 1'b0;
                            s_q        <= 2'd0;
                            b_q        <= 2'd0;
                        end
                    end
                end
                S_COMPUTE: begin
                    b_q <= b_q + 2'd1;
                    if (b_q == 2'd3) begin
                        if (s_q == 2'd2) begin
                            // Slot 0 was finalised earlier in stage 2, safe to present now.
                            state_q     <= S_UNLOAD;
                            s_q         <= 2'd0;
                            n_q         <= 3'd0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            out_re_q    <= mem_re_q[0];
                            out_im_q    <= mem_im_q[0];
                        end else begin
                            s_q <= s_q + 2'd1;
                        end
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        if (n_q == 3'd7) begin
                            state_q     <= S_LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            n_q         <= 3'd0;
                            k_q         <= 3'd0;
                        end else begin
                            n_q        <= w_n_next;
                            out_last_q <= (w_n_next == 3'd7);
                            out_re_q   <= mem_re_q[w_n_next];
                            out_im_q   <= mem_im_q[w_n_next];
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_real_o  = out_re_q;
    assign out_imag_o  = out_im_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft_8p_seq.sv
`default_nettype none
// ============================================================================
// tb_ifft_8p_seq : directed bench for ifft_8p_seq with a bit-exact IFFT model.
// Revision       : 1.0
// ============================================================================
module tb_ifft_8p_seq;
    localparam int DW = 16;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, out_last;
    logic signed [DW-1:0] in_real, in_imag, out_real, out_imag;

    always #5 clk = ~clk;

    ifft_8p_seq #(.DATA_WIDTH(DW), .FRAC_BITS(8), .N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_real_i(in_real), .in_imag_i(in_imag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_real_o(out_real), .out_imag_o(out_imag),
        .out_last_o(out_last)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fr_re[8], fr_im[8];
    int m_re[8], m_im[8];
    int tw_re[4] = '{256, 181, 0, -181};
    int tw_im[4] = '{0, 181, 256, 181};
    int exp_re[$], exp_im[$], exp_idx[$];
    int cap_re[$], cap_im[$];
    int in_cnt = 0;
    int last_in_cyc = -1000;
    int last_olast_cyc = -1000;
    bit chk_b2b = 1'b0;
    bit stall_prev = 1'b0;
    bit ov_prev = 1'b0;
    int prev_re, prev_im, prev_last;
    int ready_mode = 0;
    int rt_re[3][8], rt_im[3][8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        n_tests++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", name, act, exp, tol, cyc);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int bitrev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // In-place decimation-in-time IFFT with halving at every stage.
    task automatic model_compute();
        int ar[8], ai[8];
        int h, top, bot, t, pr, p_i, a_r, a_i;
        for (int k = 0; k < 8; k++) begin
            ar[bitrev3(k)] = fr_re[k];
            ai[bitrev3(k)] = fr_im[k];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    top = g + j;
                    bot = top + h;
                    t   = j * (4 / h);
                    pr  = (ar[bot] * tw_re[t] - ai[bot] * tw_im[t]) >>> 8;
                    p_i = (ar[bot] * tw_im[t] + ai[bot] * tw_re[t]) >>> 8;
                    a_r = ar[top];
                    a_i = ai[top];
                    ar[top] = (a_r + pr) >>> 1;
                    ai[top] = (a_i + p_i) >>> 1;
                    ar[bot] = (a_r - pr) >>> 1;
                    ai[bot] = (a_i - p_i) >>> 1;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            m_re[n] = ar[n];
            m_im[n] = ai[n];
        end
    endtask

    task automatic send_frame(input bit gaps);
        int w;
        bit hs;
        model_compute();
        for (int n = 0; n < 8; n++) begin
            exp_re.push_back(m_re[n]);
            exp_im.push_back(m_im[n]);
            exp_idx.push_back(n);
        end
        for (int k = 0; k < 8; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_real  = 16'(fr_re[k]);
            in_imag  = 16'(fr_im[k]);
            w  = 0;
            hs = 1'b0;
            while (!hs && w < 200) begin
                @(negedge clk);
                hs = in_ready;
                w++;
            end
            if (!hs) chk("in_handshake_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_caps(input int target);
        int w = 0;
        while (cap_re.size() < target && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (cap_re.size() < target) chk("out_frame_timeout", cap_re.size(), target);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    // Single compare process: every output handshake against the model queue.
    initial begin
        int er, ei, ek;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_re.delete();
                exp_im.delete();
                exp_idx.delete();
                stall_prev = 1'b0;
                ov_prev    = 1'b0;
                in_cnt     = 0;
            end else begin
                chk("ready_valid_exclusive", int'(in_ready & out_valid), 0);
                if (out_valid && !ov_prev) chk("latency", cyc - last_in_cyc, 13);
                if (stall_prev) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_re", int'(out_real), prev_re);
                    chk("hold_im", int'(out_imag), prev_im);
                    chk("hold_last", int'(out_last), prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_re.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        er = exp_re.pop_front();
                        ei = exp_im.pop_front();
                        ek = exp_idx.pop_front();
                        chk("out_re", int'(out_real), er);
                        chk("out_im", int'(out_imag), ei);
                        chk("out_last", int'(out_last), int'(ek == 7));
                        cap_re.push_back(int'(out_real));
                        cap_im.push_back(int'(out_imag));
                        if (out_last) last_olast_cyc = cyc;
                    end
                end
                if (in_valid && in_ready) begin
                    if (in_cnt % 8 == 0 && chk_b2b) chk("b2b_accept", cyc - last_olast_cyc, 1);
                    in_cnt++;
                    if (in_cnt % 8 == 0) last_in_cyc = cyc;
                end
                stall_prev = out_valid && !out_ready;
                prev_re    = int'(out_real);
                prev_im    = int'(out_imag);
                prev_last  = int'(out_last);
                ov_prev    = out_valid;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        real th, xr, xi;
        rst = 1'b1;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_real", int'(out_real), 0);
        chk("reset_out_imag", int'(out_imag), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Impulse at bin 0.
        clear_frame();
        fr_re[0] = 256;
        base = cap_re.size();
        send_frame(1'b0);
        wait_caps(base + 8);
        for (int n = 0; n < 8; n++) begin
            chk("impulse_re", cap_re[base + n], 32);
            chk("impulse_im", cap_im[base + n], 0);
        end

        // DC spectrum.
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 256;
            fr_im[k] = 0;
        end
        base = cap_re.size();
        send_frame(1'b0);
        wait_caps(base + 8);
        for (int n = 0; n < 8; n++) begin
            chk_tol("dc_re", cap_re[base + n], (n == 0) ? 256 : 0, 1);
            chk_tol("dc_im", cap_im[base + n], 0, 1);
        end

        // Single tone at bin 1; pin the model against hand-worked values first.
        clear_frame();
        fr_re[1] = 256;
        model_compute();
        chk("model_x1_re", m_re[1], 22);
        chk("model_x3_re", m_re[3], -23);
        chk("model_x3_im", m_im[3], 22);
        chk("model_x5_im", m_im[5], -23);
        base = cap_re.size();
        send_frame(1'b0);
        wait_caps(base + 8);
        chk("tone_x0_re", cap_re[base + 0], 32);
        chk("tone_x0_im", cap_im[base + 0], 0);
        chk("tone_x1_re", cap_re[base + 1], 22);
        chk("tone_x1_im", cap_im[base + 1], 22);
        chk("tone_x2_re", cap_re[base + 2], 0);
        chk("tone_x2_im", cap_im[base + 2], 32);
        chk("tone_x4_re", cap_re[base + 4], -32);
        chk("tone_x4_im", cap_im[base + 4], 0);
        for (int n = 0; n < 8; n++) begin
            th = 2.0 * PI * n / 8.0;
            chk_tol("tone_cos", cap_re[base + n], rnd(32.0 * $cos(th)), 1);
            chk_tol("tone_sin", cap_im[base + n], rnd(32.0 * $sin(th)), 1);
        end

        // Same random frame without and with stalls on both sides.
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = int'($urandom_range(0, 400)) - 200;
            fr_im[k] = int'($urandom_range(0, 400)) - 200;
        end
        base = cap_re.size();
        send_frame(1'b0);
        wait_caps(base + 8);
        ready_mode = 1;
        base = cap_re.size();
        send_frame(1'b1);
        wait_caps(base + 8);
        ready_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_sample_count", cap_re.size() - base, 8);
        chk("bp_queue_empty", exp_re.size(), 0);

        // Reset in the fifth compute cycle discards the frame.
        clear_frame();
        fr_re[0] = 256;
        send_frame(1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", int'(in_ready), 1);
        chk("rst_release_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        base = cap_re.size();
        send_frame(1'b0);
        wait_caps(base + 8);
        for (int n = 0; n < 8; n++) begin
            chk("post_rst_re", cap_re[base + n], 32);
            chk("post_rst_im", cap_im[base + n], 0);
        end

        // Round trip through a real-valued forward DFT, frames back to back.
        base = cap_re.size();
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                rt_re[f][n] = int'($urandom_range(0, 128)) - 64;
                rt_im[f][n] = int'($urandom_range(0, 128)) - 64;
            end
            for (int k = 0; k < 8; k++) begin
                xr = 0.0;
                xi = 0.0;
                for (int n = 0; n < 8; n++) begin
                    th = 2.0 * PI * n * k / 8.0;
                    xr = xr + rt_re[f][n] * $cos(th) + rt_im[f][n] * $sin(th);
                    xi = xi + rt_im[f][n] * $cos(th) - rt_re[f][n] * $sin(th);
                end
                fr_re[k] = rnd(xr);
                fr_im[k] = rnd(xi);
            end
            send_frame(1'b0);
            chk_b2b = 1'b1;
        end
        wait_caps(base + 24);
        chk_b2b = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) begin
                chk_tol("roundtrip_re", cap_re[base + 8 * f + n], rt_re[f][n], 2);
                chk_tol("roundtrip_im", cap_im[base + 8 * f + n], rt_im[f][n], 2);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_re.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
